rr_arb_mux: RTL

Parametrised, registered N-to-1 datapath selector with valid/ready handshakes and round-robin arbitration. It replaces the fixed 8:1 32-bit combinational mux wherever several producers share one consumer and a static select would stall or drop data. A forced-select mode keeps the plain indexed-mux use case for callers that drive the select directly.

---
 rtl/rr_arb_mux.sv | 114 +++++++++++
 1 files changed

// File: rtl/rr_arb_mux.sv
// N-to-1 round-robin arbitrating mux with a registered output stage; 1-cycle in_valid->out_valid latency.
// Stalls all inputs while the output word is unconsumed; optional RR_ARB_MUX_STATS_EN adds a saturating xfer_count.
// Forced-select mode grants only force_sel and leaves the round-robin pointer untouched.
module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 8,
  parameter int SELW  = $clog2(N)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N-1:0][WIDTH-1:0]   in_data,
  input  logic [N-1:0]              in_valid,
  output logic [N-1:0]              in_ready,
  input  logic                      force_en,
  input  logic [SELW-1:0]           force_sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef RR_ARB_MUX_STATS_EN
  ,
  output logic [15:0]               xfer_count
`endif
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             rr_found;
  logic [SELW-1:0]  rr_idx;
  logic [SELW-1:0]  cand;
  logic             gnt_found;
  logic [SELW-1:0]  gnt_idx;
  logic             load;
  logic             xfer;

  // Scan downward from ptr+N-1 to ptr so the closest requester after ptr wins last.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = ptr_q + SELW'(k);
      if (in_valid[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  assign gnt_found = force_en ? in_valid[force_sel] : rr_found;
  assign gnt_idx   = force_en ? force_sel : rr_idx;
  assign load      = !out_valid_q || out_ready;
  assign xfer      = !reset && load && gnt_found;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = xfer && (gnt_idx == SELW'(i));
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[gnt_idx];
      out_sel_d   = gnt_idx;
      if (!force_en) begin
        ptr_d = gnt_idx + SELW'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

`ifdef RR_ARB_MUX_STATS_EN
  logic [15:0] xfer_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_count_q <= '0;
    end else if (xfer && (xfer_count_q != 16'hFFFF)) begin
      xfer_count_q <= xfer_count_q + 16'd1;
    end
  end

  assign xfer_count = xfer_count_q;
`endif

endmodule
